// File: rtl/uart_txfifo_pkg.sv
// Shared constants for the UART TX buffer: register map, STATUS bit positions,
// master state encoding and the downstream UART data register offset.
package uart_txfifo_pkg;

  localparam logic [3:0] REG_DATA    = 4'h0;
  localparam logic [3:0] REG_STATUS  = 4'h4;
  localparam logic [3:0] REG_DROPCNT = 4'h8;

  localparam logic [3:0] UART_DATA_ADR = 4'h4;

  localparam int ST_BIT_EMPTY = 16;
  localparam int ST_BIT_FULL  = 17;
  localparam int ST_BIT_OVF   = 18;
  localparam int ST_BIT_BUSY  = 19;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } m_state_t;

endpackage

// File: rtl/uart_fifo_sync.sv
// Single-clock byte FIFO with combinational head; push is ignored when full and
// pop is ignored when empty, so callers may drive raw requests.
module uart_fifo_sync #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [7:0]            din,
  input  logic                  pop,
  output logic [7:0]            head,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // Level only reaches DEPTH when full, so its MSB alone marks the full state.
  assign full    = level[DEPTH_LOG2];
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + {{DEPTH_LOG2{1'b0}}, 1'b1};
        2'b01:   level <= level - {{DEPTH_LOG2{1'b0}}, 1'b1};
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_txfifo_wb.sv
// Wishbone TX byte buffer in front of simpleuart: CPU writes are queued and a
// Wishbone master drains them to the UART. UART_TXFIFO_DROPCNT_EN adds a drop counter at 0x8.
module uart_txfifo_wb
  import uart_txfifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rstn_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [3:0]  m_adr_o,
  output logic [31:0] m_dat_o,
  output logic [3:0]  m_sel_o,
  output logic        m_we_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  input  logic        m_ack_i,
  output logic        irq_empty_o
);

  // Handshake: a slave access is cyc&stb; ack follows one cycle later for one cycle
  // and all side effects land in that ack cycle. The master raises cyc/stb with data
  // and holds all three unchanged until it sees m_ack_i, then drops for at least a cycle.

  logic                slv_acc;
  logic                wr_data;
  logic                wr_status;
  logic                push_drop;
  logic                overflow;
  logic [31:0]         status_word;
  logic [31:0]         dropcnt_rd;

  logic [7:0]          fifo_head;
  logic [DEPTH_LOG2:0] fifo_level;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;

  m_state_t            state;
  m_state_t            state_d;
  logic                load_head;

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      wb_ack_o <= 1'b0;
    end else begin
      wb_ack_o <= wb_cyc_i & wb_stb_i & ~wb_ack_o;
    end
  end

  assign slv_acc   = wb_ack_o & wb_cyc_i & wb_stb_i;
  assign wr_data   = slv_acc & wb_we_i & (wb_adr_i == REG_DATA) & wb_sel_i[0];
  assign wr_status = slv_acc & wb_we_i & (wb_adr_i == REG_STATUS);
  // Fullness is judged before any same-cycle pop, so a drain never rescues a push.
  assign push_drop = wr_data & fifo_full;

  uart_fifo_sync #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rstn_i),
    .push  (wr_data),
    .din   (wb_dat_i[7:0]),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      overflow <= 1'b0;
    end else if (push_drop) begin
      overflow <= 1'b1;
    end else if (wr_status && wb_dat_i[ST_BIT_OVF]) begin
      overflow <= 1'b0;
    end
  end

`ifdef UART_TXFIFO_DROPCNT_EN
  logic [15:0] drop_cnt;
  logic        wr_dropcnt;

  assign wr_dropcnt = slv_acc & wb_we_i & (wb_adr_i == REG_DROPCNT);

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      drop_cnt <= '0;
    end else if (wr_dropcnt) begin
      drop_cnt <= '0;
    end else if (push_drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign dropcnt_rd = {16'b0, drop_cnt};
`else
  assign dropcnt_rd = '0;
`endif

  always_comb begin
    status_word                 = '0;
    status_word[DEPTH_LOG2:0]   = fifo_level;
    status_word[ST_BIT_EMPTY]   = fifo_empty;
    status_word[ST_BIT_FULL]    = fifo_full;
    status_word[ST_BIT_OVF]     = overflow;
    status_word[ST_BIT_BUSY]    = (state == ST_REQ);
  end

  always_comb begin
    wb_dat_o = '0;
    if (wb_ack_o && !wb_we_i) begin
      case (wb_adr_i)
        REG_STATUS:  wb_dat_o = status_word;
        REG_DROPCNT: wb_dat_o = dropcnt_rd;
        default:     wb_dat_o = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state   <= ST_IDLE;
      m_dat_o <= '0;
    end else begin
      state <= state_d;
      if (load_head) begin
        m_dat_o <= {24'b0, fifo_head};
      end
    end
  end

  always_comb begin
    state_d   = state;
    load_head = 1'b0;
    fifo_pop  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          load_head = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (m_ack_i) begin
          fifo_pop = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign m_cyc_o     = (state == ST_REQ);
  assign m_stb_o     = m_cyc_o;
  assign m_adr_o     = UART_DATA_ADR;
  assign m_sel_o     = 4'b0001;
  assign m_we_o      = 1'b1;
  assign irq_empty_o = fifo_empty & (state == ST_IDLE);

endmodule

// File: tb/tb_uart_txfifo_wb.sv
// Self-checking bench for uart_txfifo_wb: queue-based reference model of the
// buffered bytes, overflow flag and drop count, plus a UART-side responder/scoreboard.
module tb_uart_txfifo_wb;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst_n;
  logic [3:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic [3:0]  m_adr_o;
  logic [31:0] m_dat_o;
  logic [3:0]  m_sel_o;
  logic        m_we_o;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic        m_ack_i;
  logic        irq_empty_o;

  int tests_run = 0;
  int fails     = 0;

  // Reference model: bytes accepted but not yet delivered, in delivery order.
  logic [7:0] exp_q[$];
  logic       model_ovf;
  int         model_drop;

  bit ack_en;
  bit rand_delay;
  int ack_delay;
  bit ack_pulse_req;
  int txn_count;

  uart_txfifo_wb dut (
    .wb_clk_i    (clk),
    .wb_rstn_i   (rst_n),
    .wb_adr_i    (wb_adr_i),
    .wb_dat_i    (wb_dat_i),
    .wb_sel_i    (wb_sel_i),
    .wb_we_i     (wb_we_i),
    .wb_cyc_i    (wb_cyc_i),
    .wb_stb_i    (wb_stb_i),
    .wb_dat_o    (wb_dat_o),
    .wb_ack_o    (wb_ack_o),
    .m_adr_o     (m_adr_o),
    .m_dat_o     (m_dat_o),
    .m_sel_o     (m_sel_o),
    .m_we_o      (m_we_o),
    .m_cyc_o     (m_cyc_o),
    .m_stb_o     (m_stb_o),
    .m_ack_i     (m_ack_i),
    .irq_empty_o (irq_empty_o)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $fatal(1, "watchdog");
  end

  // UART-side responder and scoreboard
  initial begin : responder
    bit         in_txn;
    int         cnt;
    logic [31:0] held;
    logic [7:0] acked_byte;
    logic [7:0] exp_b;
    m_ack_i = 1'b0;
    in_txn  = 0;
    cnt     = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        m_ack_i       = 1'b0;
        in_txn        = 0;
        ack_pulse_req = 0;
      end else if (m_ack_i) begin
        m_ack_i = 1'b0;
        in_txn  = 0;
        txn_count++;
        tests_run++;
        if (m_cyc_o !== 1'b0) begin
          fails++;
          $display("FAIL idle_gap: m_cyc_o=%b after ack, required 0", m_cyc_o);
        end
        tests_run++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_txn: byte=%02h delivered, required none", acked_byte);
        end else begin
          exp_b = exp_q.pop_front();
          if (acked_byte !== exp_b) begin
            fails++;
            $display("FAIL order: delivered %02h, required %02h", acked_byte, exp_b);
          end
        end
      end else if (m_cyc_o) begin
        if (!in_txn) begin
          in_txn = 1;
          held   = m_dat_o;
          cnt    = 0;
          if (rand_delay) ack_delay = $urandom_range(0, 3);
          tests_run++;
          if ({m_stb_o, m_adr_o, m_sel_o, m_we_o, m_dat_o[31:8]} !==
              {1'b1, 4'h4, 4'b0001, 1'b1, 24'h0}) begin
            fails++;
            $display("FAIL master_fields: stb=%b adr=%h sel=%b we=%b dat=%h, required 1 4 0001 1 0000_00xx",
                     m_stb_o, m_adr_o, m_sel_o, m_we_o, m_dat_o);
          end
        end else begin
          tests_run++;
          if ({m_stb_o, m_dat_o} !== {1'b1, held}) begin
            fails++;
            $display("FAIL req_stable: stb=%b dat=%h, required 1 %h", m_stb_o, m_dat_o, held);
          end
        end
        if (ack_pulse_req || (ack_en && cnt >= ack_delay)) begin
          m_ack_i       = 1'b1;
          acked_byte    = m_dat_o[7:0];
          ack_pulse_req = 0;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Driver: one slave access; also updates the reference model in the ack cycle.
  task automatic wb_access(input logic [3:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, input bit pulse,
                           output logic [31:0] rdata, output logic [31:0] exp_stat,
                           output bit ack_ok);
    logic a0, a1, a2;
    int   sz;
    @(posedge clk);
    #2;
    wb_adr_i = adr;
    wb_dat_i = dat;
    wb_sel_i = sel;
    wb_we_i  = we;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    a0 = wb_ack_o;
    if (pulse) ack_pulse_req = 1;
    @(posedge clk);
    #2;
    a1    = wb_ack_o;
    rdata = wb_dat_o;
    sz    = exp_q.size();
    exp_stat = '0;
    exp_stat[4:0] = sz[4:0];
    exp_stat[16]  = (sz == 0);
    exp_stat[17]  = (sz >= DEPTH);
    exp_stat[18]  = model_ovf;
    if (we) begin
      if (adr == 4'h0 && sel[0]) begin
        if (sz >= DEPTH) begin
          model_ovf = 1'b1;
          if (model_drop < 65535) model_drop++;
        end else begin
          exp_q.push_back(dat[7:0]);
        end
      end else if (adr == 4'h4 && dat[18]) begin
        model_ovf = 1'b0;
      end else if (adr == 4'h8) begin
        model_drop = 0;
      end
    end
    @(posedge clk);
    #2;
    a2 = wb_ack_o;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    ack_ok = (a0 === 1'b0) && (a1 === 1'b1) && (a2 === 1'b0);
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk);
      #3;
      if (exp_q.size() == 0 && !m_cyc_o && !m_ack_i) done = 1;
    end
    tests_run++;
    if (!done) begin
      fails++;
      $display("FAIL %s_drain_timeout: %0d bytes left, required 0", name, exp_q.size());
    end
    @(posedge clk);
    #3;
    tests_run++;
    if (irq_empty_o !== 1'b1) begin
      fails++;
      $display("FAIL %s_irq_empty: got %b, required 1", name, irq_empty_o);
    end
  endtask

  function automatic logic [31:0] exp_dropcnt();
`ifdef UART_TXFIFO_DROPCNT_EN
    return 32'(model_drop);
`else
    return 32'h0;
`endif
  endfunction

  task automatic test_reset();
    logic [31:0] rd, es;
    bit ok;
    tests_run++;
    if ({wb_ack_o, m_cyc_o, m_stb_o, m_dat_o, irq_empty_o} !== {3'b000, 32'h0, 1'b1}) begin
      fails++;
      $display("FAIL reset_outputs: ack=%b cyc=%b stb=%b dat=%h irq=%b, required 0 0 0 0 1",
               wb_ack_o, m_cyc_o, m_stb_o, m_dat_o, irq_empty_o);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    wb_access(4'h4, 1'b0, 32'h0, 4'hF, 0, rd, es, ok);
    tests_run++;
    if (rd !== 32'h0001_0000 || !ok) begin
      fails++;
      $display("FAIL reset_status: got %h ack_ok=%0d, required 00010000 ack_ok=1", rd, ok);
    end
  endtask

  task automatic test_single_byte();
    logic [31:0] rd, es;
    bit ok;
    int t0;
    t0 = txn_count;
    ack_en = 1; rand_delay = 0; ack_delay = 3;
    wb_access(4'h0, 1'b1, 32'h0000_0041, 4'b0001, 0, rd, es, ok);
    tests_run++;
    if (!ok) begin
      fails++;
      $display("FAIL single_ack: ack_ok=%0d, required 1", ok);
    end
    wait_drain("single");
    tests_run++;
    if (txn_count - t0 !== 1) begin
      fails++;
      $display("FAIL single_txn_count: got %0d, required 1", txn_count - t0);
    end
  endtask

  task automatic test_fill_overflow();
    logic [31:0] rd, es;
    bit ok;
    ack_en = 0;
    for (int i = 0; i < DEPTH; i++)
      wb_access(4'h0, 1'b1, $urandom, 4'b0001, 0, rd, es, ok);
    wb_access(4'h4, 1'b0, 32'h0, 4'hF, 0, rd, es, ok);
    tests_run++;
    if (rd[18:0] !== {1'b0, 1'b1, 1'b0, 11'b0, 5'd16}) begin
      fails++;
      $display("FAIL full_status: got %h, required level=16 full=1 empty=0 ovf=0", rd);
    end
    tests_run++;
    if (rd[19] !== 1'b1) begin
      fails++;
      $display("FAIL full_busy: got %b, required 1", rd[19]);
    end
    wb_access(4'h0, 1'b1, 32'h0000_00EE, 4'b0001, 0, rd, es, ok);
    tests_run++;
    if (!ok) begin
      fails++;
      $display("FAIL overflow_ack: ack_ok=%0d, required 1", ok);
    end
    wb_access(4'h4, 1'b0, 32'h0, 4'hF, 0, rd, es, ok);
    tests_run++;
    if (rd[18:0] !== es[18:0] || rd[18] !== 1'b1) begin
      fails++;
      $display("FAIL overflow_status: got %h, required %h", rd, es);
    end
    wb_access(4'h8, 1'b0, 32'h0, 4'hF, 0, rd, es, ok);
    tests_run++;
    if (rd !== exp_dropcnt()) begin
      fails++;
      $display("FAIL dropcnt_one: got %h, required %h", rd, exp_dropcnt());
    end
  endtask

  task automatic test_drain_all();
    logic [31:0] rd, es;
    bit ok;
    int t0;
    t0 = txn_count;
    rand_delay = 1;
    ack_en = 1;
    wait_drain("drain16");
    tests_run++;
    if (txn_count - t0 !== 16) begin
      fails++;
      $display("FAIL drain16_count: got %0d, required 16", txn_count - t0);
    end
    wb_access(4'h4, 1'b0, 32'h0, 4'hF, 0, rd, es, ok);
    tests_run++;
    if (rd !== es) begin
      fails++;
      $display("FAIL drain16_status: got %h, required %h", rd, es);
    end
  endtask

  task automatic test_push_pop_same_cycle();
    logic [31:0] rd, es;
    bit ok;
    ack_en = 0;
    for (int i = 0; i < 5; i++)
      wb_access(4'h0, 1'b1, $urandom, 4'b0001, 0, rd, es, ok);
    for (int i = 0; i < 20; i++) begin
      wb_access(4'h0, 1'b1, $urandom, 4'b0001, 1, rd, es, ok);
      wb_access(4'h4, 1'b0, 32'h0, 4'hF, 0, rd, es, ok);
      tests_run++;
      if (rd[4:0] !== 5'd5 || rd[17:0] !== es[17:0]) begin
        fails++;
        $display("FAIL pushpop_level: iter %0d got %h, required level 5 (%h)", i, rd, es);
      end
    end
    rand_delay = 1;
    ack_en = 1;
    wait_drain("pushpop");
  endtask

  task automatic test_reset_mid_req();
    logic [31:0] rd, es;
    bit ok;
    bit saw_cyc;
    int t0;
    ack_en = 0;
    for (int i = 0; i < 3; i++)
      wb_access(4'h0, 1'b1, $urandom, 4'b0001, 0, rd, es, ok);
    @(posedge clk);
    #2;
    tests_run++;
    if (m_cyc_o !== 1'b1) begin
      fails++;
      $display("FAIL rstreq_pre: m_cyc_o=%b, required 1", m_cyc_o);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({m_cyc_o, m_stb_o, irq_empty_o} !== 3'b001) begin
      fails++;
      $display("FAIL rstreq_drop: cyc=%b stb=%b irq=%b, required 0 0 1", m_cyc_o, m_stb_o, irq_empty_o);
    end
    exp_q.delete();
    model_ovf  = 1'b0;
    model_drop = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    ack_en = 1;
    t0 = txn_count;
    saw_cyc = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #2;
      if (m_cyc_o) saw_cyc = 1;
    end
    tests_run++;
    if (saw_cyc || txn_count != t0) begin
      fails++;
      $display("FAIL rstreq_no_pop: cyc_seen=%0d txns=%0d, required 0 0", saw_cyc, txn_count - t0);
    end
    wb_access(4'h4, 1'b0, 32'h0, 4'hF, 0, rd, es, ok);
    tests_run++;
    if (rd !== 32'h0001_0000) begin
      fails++;
      $display("FAIL rstreq_status: got %h, required 00010000", rd);
    end
  endtask

  task automatic test_overflow_clear();
    logic [31:0] rd, es;
    bit ok;
    ack_en = 0;
    for (int i = 0; i < DEPTH + 1; i++)
      wb_access(4'h0, 1'b1, $urandom, 4'b0001, 0, rd, es, ok);
    wb_access(4'h4, 1'b1, 32'h0, 4'hF, 0, rd, es, ok);
    wb_access(4'h4, 1'b0, 32'h0, 4'hF, 0, rd, es, ok);
    tests_run++;
    if (rd[18] !== 1'b1 || rd[18:0] !== es[18:0]) begin
      fails++;
      $display("FAIL ovf_keep: got %h, required %h", rd, es);
    end
    wb_access(4'h4, 1'b1, 32'h0004_0000, 4'hF, 0, rd, es, ok);
    wb_access(4'h4, 1'b0, 32'h0, 4'hF, 0, rd, es, ok);
    tests_run++;
    if (rd[18] !== 1'b0 || rd[18:0] !== es[18:0]) begin
      fails++;
      $display("FAIL ovf_clear: got %h, required %h", rd, es);
    end
    wb_access(4'h0, 1'b1, 32'h55, 4'b0001, 0, rd, es, ok);
    wb_access(4'h4, 1'b0, 32'h0, 4'hF, 0, rd, es, ok);
    tests_run++;
    if (rd[18] !== 1'b1) begin
      fails++;
      $display("FAIL ovf_reset: got %b, required 1", rd[18]);
    end
    wb_access(4'h8, 1'b0, 32'h0, 4'hF, 0, rd, es, ok);
    tests_run++;
    if (rd !== exp_dropcnt()) begin
      fails++;
      $display("FAIL dropcnt_two: got %h, required %h", rd, exp_dropcnt());
    end
    wb_access(4'h8, 1'b1, 32'h0, 4'hF, 0, rd, es, ok);
    wb_access(4'h8, 1'b0, 32'h0, 4'hF, 0, rd, es, ok);
    tests_run++;
    if (rd !== 32'h0) begin
      fails++;
      $display("FAIL dropcnt_clear: got %h, required 0", rd);
    end
    rand_delay = 1;
    ack_en = 1;
    wait_drain("ovf");
  endtask

  task automatic test_random_traffic();
    logic [31:0] rd, es;
    bit ok;
    int op;
    rand_delay = 1;
    ack_en = 1;
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 9);
      if (op < 6) begin
        wb_access(4'h0, 1'b1, $urandom, 4'($urandom_range(0, 15)), 0, rd, es, ok);
        tests_run++;
        if (!ok) begin
          fails++;
          $display("FAIL rand_wr_ack: op %0d ack_ok=%0d, required 1", i, ok);
        end
      end else if (op < 8) begin
        wb_access(4'h4, 1'b0, 32'h0, 4'hF, 0, rd, es, ok);
        tests_run++;
        if (rd[18:0] !== es[18:0]) begin
          fails++;
          $display("FAIL rand_status: op %0d got %h, required %h", i, rd, es);
        end
      end else if (op == 8) begin
        wb_access(4'h0, 1'b0, 32'h0, 4'hF, 0, rd, es, ok);
        tests_run++;
        if (rd !== 32'h0) begin
          fails++;
          $display("FAIL rand_data_read: op %0d got %h, required 0", i, rd);
        end
      end else begin
        wb_access(4'h8, 1'b0, 32'h0, 4'hF, 0, rd, es, ok);
        tests_run++;
        if (rd !== exp_dropcnt()) begin
          fails++;
          $display("FAIL rand_dropcnt: op %0d got %h, required %h", i, rd, exp_dropcnt());
        end
      end
    end
    wait_drain("random");
  endtask

  initial begin
    rst_n         = 1'b0;
    wb_adr_i      = '0;
    wb_dat_i      = '0;
    wb_sel_i      = '0;
    wb_we_i       = 1'b0;
    wb_cyc_i      = 1'b0;
    wb_stb_i      = 1'b0;
    model_ovf     = 1'b0;
    model_drop    = 0;
    ack_en        = 0;
    rand_delay    = 0;
    ack_delay     = 0;
    ack_pulse_req = 0;
    txn_count     = 0;
    #3;
    test_reset();
    test_single_byte();
    test_fill_overflow();
    test_drain_all();
    test_push_pop_same_cycle();
    test_reset_mid_req();
    test_overflow_clear();
    test_random_traffic();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
